// File: rtl/fpu_result_buffer_pkg.sv
// Shared FPU configuration: fflags bit positions, in-flight depth, opcodes and
// the result-buffer entry layout used by the buffer and its storage.
package fpu_result_buffer_pkg;

  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  // Worst-case number of FPU operations that can still be in the pipe after hold.
  localparam int FPU_MAX_INFLIGHT = 6;

  localparam int XLEN     = 64;
  localparam int ROB_ID_W = 6;
  localparam int PHYS_W   = 7;
  localparam int FFLAGS_W = 5;
  localparam int ENTRY_W  = 84;

  typedef enum logic [3:0] {
    FPU_OP_ADD  = 4'd0,
    FPU_OP_SUB  = 4'd1,
    FPU_OP_MUL  = 4'd2,
    FPU_OP_DIV  = 4'd3,
    FPU_OP_SQRT = 4'd4,
    FPU_OP_FMA  = 4'd5,
    FPU_OP_CVT  = 4'd6,
    FPU_OP_CMP  = 4'd7
  } fpu_op_e;

  typedef struct packed {
    logic                exception;
    logic [PHYS_W-1:0]   phys_dest;
    logic [ROB_ID_W-1:0] rob_id;
    logic [FFLAGS_W-1:0] fflags;
    logic [XLEN-1:0]     result;
  } rb_entry_t;

  localparam int PAYLOAD_W = $bits(rb_entry_t);

endpackage

// File: rtl/fpu_rb_storage.sv
// Result entry array: one write port, one asynchronous read port, no reset.
// Each word is ENTRY_W wide; the top bit is a spare kept at zero.
module fpu_rb_storage
  import fpu_result_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [PAYLOAD_W-1:0]     wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [PAYLOAD_W-1:0]     rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= {{(ENTRY_W-PAYLOAD_W){1'b0}}, wdata_i};
    end
  end

  assign rdata_o = mem_q[raddr_i][PAYLOAD_W-1:0];

endmodule

// File: rtl/fpu_result_buffer.sv
// FPU result buffer: circular FIFO between the FPU and the CDB, with a
// registered head copy, issue hold, sticky overflow and fflags accumulation.
module fpu_result_buffer
  import fpu_result_buffer_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_THRESH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fpu_valid_i,
  input  logic [63:0]             fpu_result_i,
  input  logic [4:0]              fpu_fflags_i,
  input  logic [5:0]              fpu_rob_id_i,
  input  logic [6:0]              fpu_phys_dest_i,
  input  logic                    fpu_exception_i,
  input  logic                    flush_i,
  input  logic                    cdb_ready_i,
  output logic                    cdb_valid_o,
  output logic [63:0]             cdb_result_o,
  output logic [5:0]              cdb_rob_id_o,
  output logic [6:0]              cdb_phys_dest_o,
  output logic                    cdb_exception_o,
  input  logic                    fflags_clear_i,
  output logic [4:0]              fflags_acc_o,
  output logic                    fpu_hold_o,
  output logic                    overflow_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [FFLAGS_W-1:0] acc_q, acc_d;
  rb_entry_t           head_q, head_d;

  rb_entry_t           in_entry;
  rb_entry_t           rd_entry;
  logic                full;
  logic                pop;
  logic                push;
  logic [FFLAGS_W-1:0] popped_flags;

  assign in_entry = '{exception: fpu_exception_i, phys_dest: fpu_phys_dest_i,
                      rob_id: fpu_rob_id_i, fflags: fpu_fflags_i, result: fpu_result_i};

  assign full = (count_q == CW'(DEPTH));
  assign pop  = (count_q != '0) && cdb_ready_i;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push = fpu_valid_i && !flush_i && (!full || pop);

  fpu_rb_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_entry),
    .raddr_i (rd_ptr_d),
    .rdata_o (rd_entry)
  );

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    popped_flags = '0;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + AW'(1);
        popped_flags = head_q.fflags;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
    overflow_d = overflow_q | (fpu_valid_i & ~flush_i & full & ~pop);
    acc_d      = (fflags_clear_i ? '0 : acc_q) | popped_flags;
    // The new head may be the entry being written this cycle; bypass the array.
    head_d     = (push && (wr_ptr_q == rd_ptr_d)) ? in_entry : rd_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      acc_q      <= '0;
      head_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      acc_q      <= acc_d;
      head_q     <= head_d;
    end
  end

  always_comb begin
    fpu_hold_o = 1'b0;
    if (rst_n) begin
      fpu_hold_o = (int'(count_q) >= HOLD_THRESH) ||
                   ((int'(count_q) + int'(fpu_valid_i)) > (DEPTH - FPU_MAX_INFLIGHT));
    end
  end

  assign cdb_valid_o     = (count_q != '0);
  assign cdb_result_o    = head_q.result;
  assign cdb_rob_id_o    = head_q.rob_id;
  assign cdb_phys_dest_o = head_q.phys_dest;
  assign cdb_exception_o = head_q.exception;
  assign fflags_acc_o    = acc_q;
  assign overflow_o      = overflow_q;
  assign count_o         = count_q;

endmodule
